// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction-fetch front end: PC generator, fixed-latency imem port, prefetch FIFO
module fetch_queue #(
   parameter int              XLEN       = 32,
   parameter int              FIFO_DEPTH = 4,
   parameter logic [XLEN-1:0] RESET_PC   = '0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          redirect,
   input  logic [XLEN-1:0]               redirect_pc,
   output logic                          imem_req,
   output logic [XLEN-1:0]               imem_addr,
   input  logic [31:0]                   imem_rdata,
   output logic                          d_valid,
   input  logic                          d_ready,
   output logic [31:0]                   d_inst,
   output logic [XLEN-1:0]               d_pc,
   output logic [$clog2(FIFO_DEPTH):0]   occupancy
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] tag;
   logic            pend;
   logic [PW-1:0]   head;
   logic [PW-1:0]   tail;
   logic [CW-1:0]   count;

   logic [31:0]     q_inst [FIFO_DEPTH];
   logic [XLEN-1:0] q_pc4  [FIFO_DEPTH];

   logic            pop;
   logic            push;
   logic [CW:0]     fill;
   logic            unused_lsb;

   // Target low bits are dropped: fetch addresses are always word aligned.
   assign unused_lsb = ^redirect_pc[1:0];

   assign d_valid = (count != '0) & ~redirect;
   assign pop     = d_valid & d_ready;
   // A response is only kept if its request survived and no redirect squashes it now.
   assign push    = pend & ~redirect;

   // Slots committed = stored + in flight, with credit for the slot popped this cycle.
   assign fill     = {1'b0, count} + {{CW{1'b0}}, pend} - {{CW{1'b0}}, pop};
   assign imem_req = ~redirect & (fill < DEPTH_W);
   assign imem_addr = pc;

   assign d_inst    = d_valid ? q_inst[head] : 32'h0;
   assign d_pc      = d_valid ? q_pc4[head]  : '0;
   assign occupancy = count;

   // Control state: PC generation, in-flight tracking and FIFO pointers; redirect flushes all.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc    <= RESET_PC;
         tag   <= RESET_PC;
         pend  <= 1'b0;
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (redirect) begin
         pc    <= {redirect_pc[XLEN-1:2], 2'b00};
         pend  <= 1'b0;
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         pend <= imem_req;
         if (imem_req) begin
            tag <= pc;
            pc  <= pc + XLEN'(4);
         end
         if (pop)
            head <= head + PW'(1);
         if (push)
            tail <= tail + PW'(1);
         count <= count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
      end
   end

   // Entry storage: the response is written at the tail together with its own pc+4.
   always_ff @(posedge clk) begin
      if (push) begin
         q_inst[tail] <= imem_rdata;
         q_pc4[tail]  <= tag + XLEN'(4);
      end
   end

endmodule
